// File: rtl/mu_scheduler.sv
// rtl/mu_scheduler.sv - multiply-unit issue scheduler with fixed-latency completion tracker
module mu_scheduler #(
    parameter int LAT  = 3,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    input  logic            req_is_mul,
    input  logic [1:0]      req_funct3,
    input  logic [RA_W-1:0] req_rd,
    input  logic [RA_W-1:0] req_rs1,
    input  logic [RA_W-1:0] req_rs2,
    input  logic            req_rs1_used,
    input  logic            req_rs2_used,
    input  logic            flush,
    input  logic            alu_wb_valid,
    input  logic            mu_done,
    output logic            req_ready,
    output logic            mul_en,
    output logic [1:0]      mul_funct3,
    output logic            wb_sel_mu,
    output logic [RA_W-1:0] wb_rd,
    output logic            alu_wb_stall,
    output logic [2:0]      inflight,
    output logic            sync_err
);

    logic [LAT-1:0]  r_vld;
    logic [RA_W-1:0] r_rd [LAT];
    logic [2:0]      r_inflight;
    logic            r_sync_err;

    logic            w_hazard;
    logic            w_issue;
    logic [2:0]      w_inflight_nxt;

    // Hazard against every stage still in flight; the last stage is writing
    // back this cycle, so its result is already available to the requester.
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            if (r_vld[k] && (r_rd[k] != '0) &&
                ((req_rs1_used && (r_rd[k] == req_rs1)) ||
                 (req_rs2_used && (r_rd[k] == req_rs2)) ||
                 (r_rd[k] == req_rd))) begin
                w_hazard = 1'b1;
            end
        end
        w_hazard = w_hazard & req_valid;
    end

    assign w_issue      = req_valid & req_is_mul & ~w_hazard & ~flush;
    assign req_ready    = ~w_hazard;
    assign mul_en       = w_issue;
    assign mul_funct3   = w_issue ? req_funct3 : 2'b00;
    assign wb_sel_mu    = r_vld[LAT-1];
    assign wb_rd        = r_vld[LAT-1] ? r_rd[LAT-1] : '0;
    assign alu_wb_stall = alu_wb_valid & r_vld[LAT-1];
    assign inflight     = r_inflight;
    assign sync_err     = r_sync_err;

    // Occupancy after the coming edge: the new issue plus every stage that shifts on.
    always_comb begin
        w_inflight_nxt = {2'b00, w_issue};
        for (int k = 0; k < LAT - 1; k++) begin
            w_inflight_nxt = w_inflight_nxt + {2'b00, r_vld[k]};
        end
    end

    // Free-running shift tracker; stage 0 captures the issue, others shift down.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_vld[0] <= w_issue;
            r_rd[0]  <= w_issue ? req_rd : '0;
            for (int k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
        end
    end

    // Registered occupancy count and sticky completion-mismatch flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_sync_err <= r_sync_err | (mu_done != r_vld[LAT-1]);
        end
    end

endmodule

// File: tb/tb_mu_scheduler.sv
// tb/tb_mu_scheduler.sv - self-checking bench for mu_scheduler
module tb_mu_scheduler;
    localparam int LAT  = 3;
    localparam int RA_W = 5;
    localparam int HMAX = 8192;

    logic            clk = 1'b0;
    logic            rstn;
    logic            req_valid, req_is_mul, req_rs1_used, req_rs2_used;
    logic [1:0]      req_funct3;
    logic [RA_W-1:0] req_rd, req_rs1, req_rs2;
    logic            flush, alu_wb_valid, mu_done;
    logic            req_ready, mul_en, wb_sel_mu, alu_wb_stall, sync_err;
    logic [1:0]      mul_funct3;
    logic [RA_W-1:0] wb_rd;
    logic [2:0]      inflight;

    always #5 clk = ~clk;

    mu_scheduler #(.LAT(LAT), .RA_W(RA_W)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_is_mul(req_is_mul), .req_funct3(req_funct3),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_rs1_used(req_rs1_used), .req_rs2_used(req_rs2_used),
        .flush(flush), .alu_wb_valid(alu_wb_valid), .mu_done(mu_done),
        .req_ready(req_ready), .mul_en(mul_en), .mul_funct3(mul_funct3),
        .wb_sel_mu(wb_sel_mu), .wb_rd(wb_rd), .alu_wb_stall(alu_wb_stall),
        .inflight(inflight), .sync_err(sync_err)
    );

    int checks = 0;
    int errors = 0;

    // Model: per-cycle issue history; an issue at cycle k completes at k+LAT.
    bit              hist_v  [HMAX];
    logic [RA_W-1:0] hist_rd [HMAX];
    int              c = 0;
    int              base = 0;
    bit              model_err = 1'b0;
    bit              e_issue;
    bit              md_ovr = 1'b0;
    bit              md_val = 1'b0;

    function automatic bit iss(int k);
        if (k < 0 || k < base) return 1'b0;
        return hist_v[k];
    endfunction

    function automatic logic [RA_W-1:0] iss_rd(int k);
        if (!iss(k)) return '0;
        return hist_rd[k];
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        for (int j = 1; j < LAT; j++) begin
            if (iss(c - j) && hist_rd[c-j] != 0) begin
                if ((req_rs1_used && hist_rd[c-j] == req_rs1) ||
                    (req_rs2_used && hist_rd[c-j] == req_rs2) ||
                    (hist_rd[c-j] == req_rd))
                    h = 1'b1;
            end
        end
        return h & req_valid;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic clr_in();
        req_valid = 0; req_is_mul = 0; req_funct3 = 0;
        req_rd = 0; req_rs1 = 0; req_rs2 = 0;
        req_rs1_used = 0; req_rs2_used = 0;
        flush = 0; alu_wb_valid = 0;
        md_ovr = 0; md_val = 0;
    endtask

    // Drive mu_done, move to the sampling edge and compare every output with the model.
    task automatic cyc_begin();
        bit haz;
        bit e_wb;
        int cnt;
        mu_done = md_ovr ? md_val : iss(c - LAT);
        @(negedge clk);
        haz     = m_hazard();
        e_issue = rstn ? (req_valid && req_is_mul && !haz && !flush) : 1'b0;
        e_wb    = iss(c - LAT);
        cnt = 0;
        for (int j = 1; j <= LAT; j++) cnt += int'(iss(c - j));
        chk("req_ready",    {31'd0, req_ready}, {31'd0, !haz});
        chk("mul_en",       {31'd0, mul_en},    {31'd0, req_valid && req_is_mul && !haz && !flush});
        chk("mul_funct3",   {30'd0, mul_funct3}, (req_valid && req_is_mul && !haz && !flush) ? {30'd0, req_funct3} : 32'd0);
        chk("wb_sel_mu",    {31'd0, wb_sel_mu}, {31'd0, e_wb});
        chk("wb_rd",        {27'd0, wb_rd},     {27'd0, iss_rd(c - LAT)});
        chk("alu_wb_stall", {31'd0, alu_wb_stall}, {31'd0, alu_wb_valid && e_wb});
        chk("inflight",     {29'd0, inflight},  cnt);
        chk("sync_err",     {31'd0, sync_err},  {31'd0, model_err});
    endtask

    task automatic cyc_end();
        @(posedge clk);
        if (!rstn) begin
            hist_v[c] = 1'b0;
            base = c + 1;
            model_err = 1'b0;
        end else begin
            hist_v[c]  = e_issue;
            hist_rd[c] = req_rd;
            if (mu_done != iss(c - LAT)) model_err = 1'b1;
        end
        c++;
        #1;
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    task automatic do_reset(int n);
        clr_in();
        rstn = 1'b0;
        base = c;
        model_err = 1'b0;
        repeat (n) tick();
        rstn = 1'b1;
    endtask

    task automatic issue_mul(logic [RA_W-1:0] rd);
        clr_in();
        req_valid = 1; req_is_mul = 1; req_rd = rd; req_funct3 = 2'd2;
    endtask

    initial begin
        clr_in();
        rstn = 1'b0;
        mu_done = 1'b0;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_wb_sel",    {31'd0, wb_sel_mu}, 32'd0);
        chk("rst_inflight",  {29'd0, inflight},  32'd0);
        chk("rst_sync_err",  {31'd0, sync_err},  32'd0);
        @(posedge clk); #1;
        do_reset(2);

        // Single multiply, rd=5.
        issue_mul(5'd5);
        cyc_begin(); chk("d1_mul_en", {31'd0, mul_en}, 32'd1); chk("d1_f3", {30'd0, mul_funct3}, 32'd2); cyc_end();
        clr_in();
        for (int i = 1; i <= 3; i++) begin
            cyc_begin(); chk("d1_inflight", {29'd0, inflight}, 32'd1);
            if (i == 3) begin
                chk("d1_wb_sel", {31'd0, wb_sel_mu}, 32'd1);
                chk("d1_wb_rd",  {27'd0, wb_rd},     32'd5);
            end
            cyc_end();
        end
        cyc_begin(); chk("d1_sync_err", {31'd0, sync_err}, 32'd0); chk("d1_inflight0", {29'd0, inflight}, 32'd0); cyc_end();

        // Dependent add on rd=7.
        issue_mul(5'd7); tick();
        clr_in(); req_valid = 1; req_rd = 5'd10; req_rs1 = 5'd7; req_rs1_used = 1;
        cyc_begin(); chk("d2_ready_c1", {31'd0, req_ready}, 32'd0); cyc_end();
        cyc_begin(); chk("d2_ready_c2", {31'd0, req_ready}, 32'd0); cyc_end();
        cyc_begin(); chk("d2_ready_c3", {31'd0, req_ready}, 32'd1); cyc_end();
        clr_in(); repeat (LAT) tick();

        // Back-to-back rd=1,2,3.
        for (int i = 1; i <= 3; i++) begin issue_mul(RA_W'(i)); tick(); end
        clr_in();
        cyc_begin(); chk("d3_inflight", {29'd0, inflight}, 32'd3); chk("d3_wb_rd3", {27'd0, wb_rd}, 32'd1); cyc_end();
        cyc_begin(); chk("d3_wb_rd4", {27'd0, wb_rd}, 32'd2); cyc_end();
        cyc_begin(); chk("d3_wb_rd5", {27'd0, wb_rd}, 32'd3); cyc_end();
        tick();

        // Writeback contention, rd=9.
        issue_mul(5'd9); tick();
        clr_in(); tick(); tick();
        alu_wb_valid = 1;
        cyc_begin();
        chk("d4_wb_sel", {31'd0, wb_sel_mu}, 32'd1);
        chk("d4_wb_rd",  {27'd0, wb_rd},     32'd9);
        chk("d4_stall",  {31'd0, alu_wb_stall}, 32'd1);
        cyc_end();
        cyc_begin(); chk("d4_stall_next", {31'd0, alu_wb_stall}, 32'd0); cyc_end();
        clr_in(); tick();

        // Flush with a new request does not cancel the older multiply.
        issue_mul(5'd4); tick();
        issue_mul(5'd6); flush = 1;
        cyc_begin(); chk("d5_mul_en_flush", {31'd0, mul_en}, 32'd0); cyc_end();
        clr_in(); tick();
        cyc_begin(); chk("d5_wb_sel", {31'd0, wb_sel_mu}, 32'd1); chk("d5_wb_rd", {27'd0, wb_rd}, 32'd4); cyc_end();
        tick();

        // rd=0 issues, no hazard, still completes.
        issue_mul(5'd0); tick();
        clr_in(); req_valid = 1; req_rs1_used = 1;
        cyc_begin(); chk("d6_rd0_ready", {31'd0, req_ready}, 32'd1); cyc_end();
        clr_in(); tick();
        cyc_begin(); chk("d6_rd0_wb_sel", {31'd0, wb_sel_mu}, 32'd1); cyc_end();
        tick();

        // Reset mid-flight drops the multiply.
        issue_mul(5'd8); tick();
        do_reset(1);
        for (int i = 0; i < LAT + 1; i++) begin
            cyc_begin(); chk("d7_no_wb", {31'd0, wb_sel_mu}, 32'd0); cyc_end();
        end

        // Spurious completion sets the sticky error.
        do_reset(1);
        tick(); tick();
        md_ovr = 1; md_val = 1; tick();
        clr_in();
        for (int i = 0; i < 4; i++) begin
            cyc_begin(); chk("d8_sync_err", {31'd0, sync_err}, 32'd1); cyc_end();
        end
        rstn = 1'b0; #1;
        chk("d8_sync_clr", {31'd0, sync_err}, 32'd0);
        base = c; model_err = 1'b0;
        tick();
        rstn = 1'b1;

        // Randomized traffic with occasional completion glitches and resets.
        for (int i = 0; i < 2000; i++) begin
            req_valid    = $urandom_range(0, 3) != 0;
            req_is_mul   = $urandom_range(0, 1) == 1;
            req_funct3   = 2'($urandom);
            req_rd       = RA_W'($urandom_range(0, 3));
            req_rs1      = RA_W'($urandom_range(0, 3));
            req_rs2      = RA_W'($urandom_range(0, 3));
            req_rs1_used = $urandom_range(0, 1) == 1;
            req_rs2_used = $urandom_range(0, 1) == 1;
            flush        = $urandom_range(0, 6) == 0;
            alu_wb_valid = $urandom_range(0, 1) == 1;
            md_ovr       = $urandom_range(0, 99) == 0;
            md_val       = !iss(c - LAT);
            tick();
            if ($urandom_range(0, 149) == 0) do_reset(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
